// File: rtl/estagio_mem_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the data memory (slave).
interface estagio_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/estagio_mem.sv
// MEM stage of the 5-stage MIPS pipeline: variable-latency load/store with lane steering and stall.
// Defining MEM_PERF_CNT_EN adds the contaLoads/contaStores/contaStall performance counters.
//
// state   | meaning
// OCIOSO  | idle; passes non-memory ops through, launches aligned accesses
// ESPERA  | request outstanding, waiting for mem_ready or the timeout
// CONCLUI | presents the finished (or aborted) instruction to MEM_WB
module estagio_mem #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valido,
    input  logic [4:0]    controlBits,
    input  logic [31:0]   enderecoULA,
    input  logic [31:0]   dadoEscrita,
    input  logic [4:0]    escreveReg,
    input  logic [1:0]    tamanho,
    input  logic          comSinal,
    estagio_mem_if.master mem,
    output logic [31:0]   read,
    output logic [31:0]   resultadoULA,
    output logic [4:0]    saidaReg,
    output logic [1:0]    saidaControlBits,
    output logic          stall,
    output logic          erroAlinhamento,
    output logic          erroTimeout
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]   contaLoads,
    output logic [31:0]   contaStores,
    output logic [31:0]   contaStall
`endif
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    estado_t          estado_q, estado_nxt;
    logic             eh_mem, eh_store, desalinhado;
    logic [3:0]       be_novo;
    logic [31:0]      wdata_novo;
    logic             inicia, termina, aborta;
    logic             req_q, we_q, sinal_q, abort_q;
    logic [31:0]      addr_q, wdata_q, rdata_q, lido;
    logic [3:0]       be_q;
    logic [1:0]       tam_q, ctrl_q;
    logic [4:0]       reg_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             timeout_hit;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic             unused_reservado;

    assign unused_reservado = controlBits[0];
    assign eh_mem   = valido && (controlBits[4] || controlBits[3]);
    // MemRead together with MemWrite is handled as a store
    assign eh_store = controlBits[3];

    always_comb begin
        desalinhado = 1'b0;
        be_novo     = 4'b1111;
        wdata_novo  = dadoEscrita;
        case (tamanho)
            2'b00: begin
                be_novo    = 4'b0001 << enderecoULA[1:0];
                wdata_novo = {4{dadoEscrita[7:0]}};
            end
            2'b01: begin
                desalinhado = enderecoULA[0];
                be_novo     = enderecoULA[1] ? 4'b1100 : 4'b0011;
                wdata_novo  = {2{dadoEscrita[15:0]}};
            end
            default: desalinhado = (enderecoULA[1:0] != 2'b00);
        endcase
        if (!eh_store) be_novo = 4'b1111;
    end

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

    assign byte_sel = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        case (tam_q)
            2'b00:   lido = {{24{sinal_q & byte_sel[7]}}, byte_sel};
            2'b01:   lido = {{16{sinal_q & half_sel[15]}}, half_sel};
            default: lido = rdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado_q <= OCIOSO;
        else        estado_q <= estado_nxt;
    end

    always_comb begin
        estado_nxt       = estado_q;
        stall            = 1'b0;
        erroAlinhamento  = 1'b0;
        erroTimeout      = 1'b0;
        read             = 32'd0;
        resultadoULA     = 32'd0;
        saidaReg         = 5'd0;
        saidaControlBits = 2'b00;
        inicia           = 1'b0;
        termina          = 1'b0;
        aborta           = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (valido && !eh_mem) begin
                    resultadoULA     = enderecoULA;
                    saidaReg         = escreveReg;
                    saidaControlBits = controlBits[2:1];
                end else if (eh_mem && desalinhado) begin
                    erroAlinhamento = 1'b1;
                end else if (eh_mem) begin
                    stall      = 1'b1;
                    inicia     = 1'b1;
                    estado_nxt = ESPERA;
                end
            end
            ESPERA: begin
                stall = 1'b1;
                if (mem.mem_ready) begin
                    termina    = 1'b1;
                    estado_nxt = CONCLUI;
                end else if (timeout_hit) begin
                    aborta     = 1'b1;
                    estado_nxt = CONCLUI;
                end
            end
            CONCLUI: begin
                erroTimeout = abort_q;
                if (!abort_q) begin
                    read             = we_q ? 32'd0 : lido;
                    resultadoULA     = addr_q;
                    saidaReg         = reg_q;
                    saidaControlBits = ctrl_q;
                end
                estado_nxt = OCIOSO;
            end
            default: estado_nxt = OCIOSO;
        endcase
        // held reset must present a bubble even while EX_MEM shows a live instruction
        if (!reset) begin
            stall            = 1'b0;
            erroAlinhamento  = 1'b0;
            erroTimeout      = 1'b0;
            read             = 32'd0;
            resultadoULA     = 32'd0;
            saidaReg         = 5'd0;
            saidaControlBits = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sinal_q <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            be_q    <= 4'd0;
            tam_q   <= 2'd0;
            ctrl_q  <= 2'd0;
            reg_q   <= 5'd0;
            cnt_q   <= '0;
        end else begin
            if (inicia) begin
                req_q   <= 1'b1;
                we_q    <= eh_store;
                sinal_q <= comSinal;
                abort_q <= 1'b0;
                addr_q  <= enderecoULA;
                wdata_q <= wdata_novo;
                be_q    <= be_novo;
                tam_q   <= tamanho;
                ctrl_q  <= controlBits[2:1];
                reg_q   <= escreveReg;
                cnt_q   <= '0;
            end
            if (estado_q == ESPERA) cnt_q <= cnt_inc;
            if (termina) begin
                req_q <= 1'b0;
                if (!we_q) rdata_q <= mem.mem_rdata;
            end
            if (aborta) begin
                req_q   <= 1'b0;
                abort_q <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contaLoads  <= 32'd0;
            contaStores <= 32'd0;
            contaStall  <= 32'd0;
        end else begin
            if (estado_q == CONCLUI && !abort_q) begin
                if (we_q) contaStores <= contaStores + 32'd1;
                else      contaLoads  <= contaLoads + 32'd1;
            end
            if (stall) contaStall <= contaStall + 32'd1;
        end
    end
`endif

endmodule
